// File: rtl/mem_bank_pkg.sv
// mem_bank_pkg: shared encodings, field widths and descriptor type for the
// bank writer and its descriptor FIFO.
package mem_bank_pkg;

    localparam int unsigned PORT_W   = 2;
    localparam int unsigned SLOT_W   = 4;
    localparam int unsigned OFF_W    = 9;
    localparam int unsigned ADDR_W   = SLOT_W + OFF_W;
    localparam int unsigned LEN_W    = 12;
    localparam int unsigned CNT_W    = 10;
    localparam int unsigned RUNT_LEN = 64;

    typedef enum logic [1:0] {
        INFO_MID   = 2'b00,
        INFO_SOF   = 2'b01,
        INFO_EOF   = 2'b10,
        INFO_SOEOF = 2'b11
    } info_t;

    typedef enum logic [PORT_W-1:0] {
        PORT_0      = 2'b00,
        PORT_1      = 2'b01,
        PORT_UNUSED = 2'b10,
        PORT_3      = 2'b11
    } port_code_t;

    typedef enum logic [1:0] {
        CTX_IDLE,
        CTX_WRITE,
        CTX_DROP
    } ctx_state_t;

    typedef struct packed {
        logic [SLOT_W-1:0] slot;
        logic [LEN_W-1:0]  len;
        logic [PORT_W-1:0] port;
    } desc_t;

    // Byte length of a frame whose last word arrives after `words` full words.
    function automatic logic [LEN_W-1:0] frame_len(input logic [CNT_W-1:0] words,
                                                   input logic [1:0]       extra);
        logic [LEN_W-1:0] tail;
        tail = (extra == 2'd0) ? LEN_W'(4) : LEN_W'(extra);
        return {words, 2'b00} + tail;
    endfunction

endpackage

// File: rtl/mem_bank_writer_desc_fifo.sv
// desc_fifo: synchronous descriptor FIFO with valid/ready output side.
// Head fields read as zero while the FIFO is empty.
module desc_fifo
    import mem_bank_pkg::*;
#(
    parameter int unsigned pDEPTH   = 4,
    parameter int unsigned CNT_BITS = $clog2(pDEPTH + 1)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_push,
    input  desc_t               i_desc,
    input  logic                i_ready,
    output logic                o_valid,
    output desc_t               o_desc,
    output logic [CNT_BITS-1:0] o_count
);

    localparam int unsigned      PTR_W = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(pDEPTH - 1);

    desc_t               mem [pDEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_BITS-1:0] count;
    logic                do_push;
    logic                do_pop;

    assign do_pop  = (count != '0) && i_ready;
    assign do_push = i_push && (count != CNT_BITS'(pDEPTH));

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CNT_BITS'(do_push) - CNT_BITS'(do_pop);
        end
    end

    // Descriptor storage; contents are only observed through the valid gate.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_desc;
        end
    end

    assign o_valid = (count != '0);
    assign o_desc  = o_valid ? mem[rd_ptr] : '0;
    assign o_count = count;

endmodule

// File: rtl/mem_bank_writer.sv
// mem_bank_writer: writes arbiter frame words into a slot-organised bank
// SRAM, keeps per-port write context, allocates/reclaims slots and emits
// one descriptor per accepted frame.
// Optional build macro MEM_WR_RUNT_DROP_EN: frames shorter than 64 bytes
// are dropped instead of forwarded.
module mem_bank_writer
    import mem_bank_pkg::*;
#(
    parameter int unsigned pPORT_WIDTH = 4,
    parameter int unsigned pDATA_W     = 32,
    parameter int unsigned pSLOT_NUM   = 16,
    parameter int unsigned pSLOT_WORDS = 512,
    parameter int unsigned pDESC_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_en_mem,
    input  logic [pDATA_W-1:0] i_data,
    input  logic [PORT_W-1:0]  i_port_num,
    input  logic [1:0]         i_info_port,
    input  logic [1:0]         i_extra_byte,
    output logic               o_mem_we,
    output logic [ADDR_W-1:0]  o_mem_addr,
    output logic [pDATA_W-1:0] o_mem_wdata,
    output logic               o_desc_valid,
    output logic [SLOT_W-1:0]  o_desc_slot,
    output logic [LEN_W-1:0]   o_desc_len,
    output logic [PORT_W-1:0]  o_desc_port,
    input  logic               i_desc_ready,
    input  logic               i_free_valid,
    input  logic [SLOT_W-1:0]  i_free_slot,
    output logic               o_drop,
    output logic [15:0]        o_drop_cnt
);

`ifdef MEM_WR_RUNT_DROP_EN
    localparam bit RUNT_DROP = 1'b1;
`else
    localparam bit RUNT_DROP = 1'b0;
`endif

    localparam int unsigned      FIFO_CNT_W   = $clog2(pDESC_DEPTH + 1);
    localparam int unsigned      OCC_W        = FIFO_CNT_W + 1;
    localparam logic [CNT_W-1:0] SLOT_WORDS_C = CNT_W'(pSLOT_WORDS);

    ctx_state_t          ctx_st   [pPORT_WIDTH];
    logic [SLOT_W-1:0]   ctx_slot [pPORT_WIDTH];
    logic [CNT_W-1:0]    ctx_cnt  [pPORT_WIDTH];
    logic [pSLOT_NUM-1:0] free_map;

    ctx_state_t          cur_st, nx_st;
    logic [SLOT_W-1:0]   cur_slot, nx_slot;
    logic [CNT_W-1:0]    cur_cnt, nx_cnt;

    logic                word_ok, is_sof, is_eof;
    logic                alloc_ok;
    logic [SLOT_W-1:0]   alloc_slot;
    logic [pSLOT_NUM-1:0] ret_mask, take_mask, ext_mask;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic                drop_old, drop_new;
    logic [LEN_W-1:0]    word_len;
    logic                runt;
    logic                push;
    desc_t               push_desc;
    logic [16:0]         drop_sum;

    logic                pend_valid;
    desc_t               pend_desc;
    logic                fifo_valid;
    logic                fifo_pop;
    desc_t               fifo_head;
    logic [FIFO_CNT_W-1:0] fifo_cnt;
    logic [OCC_W-1:0]    occ_after;
    logic                desc_full;

    assign word_ok  = i_en_mem && (i_port_num != PORT_UNUSED);
    assign is_sof   = (i_info_port == INFO_SOF) || (i_info_port == INFO_SOEOF);
    assign is_eof   = (i_info_port == INFO_EOF) || (i_info_port == INFO_SOEOF);
    assign fifo_pop = fifo_valid && i_desc_ready;

    // A descriptor accepted this cycle lands in the FIFO one cycle later, so
    // the full test counts the staged entry and the pop happening now.
    assign occ_after = OCC_W'(fifo_cnt) + OCC_W'(pend_valid) - OCC_W'(fifo_pop);
    assign desc_full = (occ_after >= OCC_W'(pDESC_DEPTH));

    assign drop_sum = {1'b0, o_drop_cnt} + 17'(drop_old) + 17'(drop_new);

    // Lowest-index free slot and the external release mask.
    always_comb begin
        alloc_ok   = 1'b0;
        alloc_slot = '0;
        ext_mask   = '0;
        for (int unsigned i = 0; i < pSLOT_NUM; i++) begin
            if (free_map[i] && !alloc_ok) begin
                alloc_ok   = 1'b1;
                alloc_slot = SLOT_W'(i);
            end
        end
        if (i_free_valid) begin
            ext_mask[i_free_slot] = 1'b1;
        end
    end

    // Next context, SRAM write, slot bookkeeping and descriptor for this word.
    // An SOF aborts any frame in progress and then starts fresh from the
    // start-of-cycle bitmap, so it may record two drops in one cycle.
    always_comb begin
        cur_st    = ctx_st[i_port_num];
        cur_slot  = ctx_slot[i_port_num];
        cur_cnt   = ctx_cnt[i_port_num];
        nx_st     = cur_st;
        nx_slot   = cur_slot;
        nx_cnt    = cur_cnt;
        wr_en     = 1'b0;
        wr_addr   = '0;
        drop_old  = 1'b0;
        drop_new  = 1'b0;
        ret_mask  = '0;
        take_mask = '0;
        push      = 1'b0;
        push_desc = '0;
        word_len  = '0;
        runt      = 1'b0;
        if (word_ok) begin
            if (is_sof) begin
                if (cur_st == CTX_WRITE) begin
                    drop_old           = 1'b1;
                    ret_mask[cur_slot] = 1'b1;
                end
                word_len = frame_len('0, i_extra_byte);
                runt     = RUNT_DROP && (word_len < LEN_W'(RUNT_LEN));
                if (!alloc_ok) begin
                    drop_new = 1'b1;
                    nx_st    = is_eof ? CTX_IDLE : CTX_DROP;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = {alloc_slot, {OFF_W{1'b0}}};
                    if (is_eof) begin
                        nx_st = CTX_IDLE;
                        if (desc_full || runt) begin
                            drop_new = 1'b1;
                        end else begin
                            take_mask[alloc_slot] = 1'b1;
                            push      = 1'b1;
                            push_desc = '{slot: alloc_slot, len: word_len, port: i_port_num};
                        end
                    end else begin
                        take_mask[alloc_slot] = 1'b1;
                        nx_st   = CTX_WRITE;
                        nx_slot = alloc_slot;
                        nx_cnt  = CNT_W'(1);
                    end
                end
            end else begin
                case (cur_st)
                    CTX_WRITE: begin
                        word_len = frame_len(cur_cnt, i_extra_byte);
                        runt     = RUNT_DROP && (word_len < LEN_W'(RUNT_LEN));
                        if (cur_cnt >= SLOT_WORDS_C) begin
                            drop_old           = 1'b1;
                            ret_mask[cur_slot] = 1'b1;
                            nx_st              = CTX_DROP;
                        end else begin
                            wr_en   = 1'b1;
                            wr_addr = {cur_slot, cur_cnt[OFF_W-1:0]};
                            if (is_eof) begin
                                nx_st = CTX_IDLE;
                                if (desc_full || runt) begin
                                    drop_old           = 1'b1;
                                    ret_mask[cur_slot] = 1'b1;
                                end else begin
                                    push      = 1'b1;
                                    push_desc = '{slot: cur_slot, len: word_len, port: i_port_num};
                                end
                            end else begin
                                nx_cnt = cur_cnt + 1'b1;
                            end
                        end
                    end
                    CTX_DROP: begin
                        if (is_eof) begin
                            nx_st = CTX_IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Context, bitmap, registered SRAM port, drop reporting and descriptor staging.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned p = 0; p < pPORT_WIDTH; p++) begin
                ctx_st[p]   <= CTX_IDLE;
                ctx_slot[p] <= '0;
                ctx_cnt[p]  <= '0;
            end
            free_map    <= '1;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_drop      <= 1'b0;
            o_drop_cnt  <= '0;
            pend_valid  <= 1'b0;
            pend_desc   <= '0;
        end else begin
            if (word_ok) begin
                ctx_st[i_port_num]   <= nx_st;
                ctx_slot[i_port_num] <= nx_slot;
                ctx_cnt[i_port_num]  <= nx_cnt;
            end
            free_map    <= (free_map | ret_mask | ext_mask) & ~take_mask;
            o_mem_we    <= wr_en;
            o_mem_addr  <= wr_addr;
            o_mem_wdata <= i_data;
            o_drop      <= drop_old || drop_new;
            o_drop_cnt  <= drop_sum[16] ? '1 : drop_sum[15:0];
            pend_valid  <= push;
            pend_desc   <= push_desc;
        end
    end

    desc_fifo #(
        .pDEPTH   (pDESC_DEPTH),
        .CNT_BITS (FIFO_CNT_W)
    ) u_desc_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (pend_valid),
        .i_desc  (pend_desc),
        .i_ready (i_desc_ready),
        .o_valid (fifo_valid),
        .o_desc  (fifo_head),
        .o_count (fifo_cnt)
    );

    assign o_desc_valid = fifo_valid;
    assign o_desc_slot  = fifo_head.slot;
    assign o_desc_len   = fifo_head.len;
    assign o_desc_port  = fifo_head.port;

endmodule

// File: tb/tb_mem_bank_writer.sv
// tb_mem_bank_writer: directed and random stimulus for mem_bank_writer,
// checked every cycle against a frame-level reference model.
module tb_mem_bank_writer;

`ifdef MEM_WR_RUNT_DROP_EN
    localparam bit RUNT_EN = 1'b1;
`else
    localparam bit RUNT_EN = 1'b0;
`endif

    localparam int ST_IDLE = 0;
    localparam int ST_WR   = 1;
    localparam int ST_DROP = 2;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_en_mem = 1'b0;
    logic [31:0] i_data = '0;
    logic [1:0]  i_port_num = '0;
    logic [1:0]  i_info_port = '0;
    logic [1:0]  i_extra_byte = '0;
    logic        i_desc_ready = 1'b1;
    logic        i_free_valid = 1'b0;
    logic [3:0]  i_free_slot = '0;
    logic        o_mem_we;
    logic [12:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_desc_valid;
    logic [3:0]  o_desc_slot;
    logic [11:0] o_desc_len;
    logic [1:0]  o_desc_port;
    logic        o_drop;
    logic [15:0] o_drop_cnt;

    always #5 i_clk = ~i_clk;

    mem_bank_writer dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_en_mem     (i_en_mem),
        .i_data       (i_data),
        .i_port_num   (i_port_num),
        .i_info_port  (i_info_port),
        .i_extra_byte (i_extra_byte),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_desc_valid (o_desc_valid),
        .o_desc_slot  (o_desc_slot),
        .o_desc_len   (o_desc_len),
        .o_desc_port  (o_desc_port),
        .i_desc_ready (i_desc_ready),
        .i_free_valid (i_free_valid),
        .i_free_slot  (i_free_slot),
        .o_drop       (o_drop),
        .o_drop_cnt   (o_drop_cnt)
    );

    typedef struct {
        int slot;
        int len;
        int port;
        int vis;
    } mdesc_t;

    mdesc_t      mq[$];
    int          held[$];
    int          m_st   [4];
    int          m_slot [4];
    int          m_cnt  [4];
    bit          m_free [16];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          e_we;
    bit          e_drop;
    bit          e_rst;
    int          e_addr;
    logic [31:0] e_wdata;
    int          e_dcnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit is_runt(input int len);
        return RUNT_EN && (len < 64);
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < 16; i++) begin
            if (m_free[i]) return i;
        end
        return -1;
    endfunction

    // Apply the current inputs to the model, clock once, compare outputs.
    task automatic tick();
        int  drops;
        int  frees[$];
        int  take;
        int  s;
        int  len;
        int  p;
        bit  sof;
        bit  eof;
        bit  full;
        bit  ev;
        drops = 0;
        take  = -1;
        e_we  = 1'b0;
        e_rst = i_reset;
        if (i_reset) begin
            for (int k = 0; k < 4; k++) begin
                m_st[k] = ST_IDLE;
                m_cnt[k] = 0;
                m_slot[k] = 0;
            end
            for (int k = 0; k < 16; k++) m_free[k] = 1'b1;
            mq.delete();
            held.delete();
            e_dcnt = 0;
        end else begin
            if (mq.size() > 0 && mq[0].vis < cyc && i_desc_ready) begin
                held.push_back(mq[0].slot);
                void'(mq.pop_front());
            end
            if (i_free_valid) frees.push_back(int'(i_free_slot));
            if (i_en_mem && i_port_num != 2'b10) begin
                p    = int'(i_port_num);
                sof  = i_info_port[0];
                eof  = i_info_port[1];
                full = (mq.size() >= 4);
                s    = lowest_free();
                if (sof) begin
                    if (m_st[p] == ST_WR) begin
                        drops++;
                        frees.push_back(m_slot[p]);
                    end
                    if (s < 0) begin
                        drops++;
                        m_st[p] = eof ? ST_IDLE : ST_DROP;
                    end else begin
                        e_we = 1'b1;
                        e_addr = s * 512;
                        e_wdata = i_data;
                        if (eof) begin
                            len = (i_extra_byte == 2'd0) ? 4 : int'(i_extra_byte);
                            m_st[p] = ST_IDLE;
                            if (full || is_runt(len)) drops++;
                            else begin
                                take = s;
                                mq.push_back('{s, len, p, cyc + 1});
                            end
                        end else begin
                            take = s;
                            m_st[p] = ST_WR;
                            m_slot[p] = s;
                            m_cnt[p] = 1;
                        end
                    end
                end else if (m_st[p] == ST_WR) begin
                    if (m_cnt[p] >= 512) begin
                        drops++;
                        frees.push_back(m_slot[p]);
                        m_st[p] = ST_DROP;
                    end else begin
                        e_we = 1'b1;
                        e_addr = m_slot[p] * 512 + m_cnt[p];
                        e_wdata = i_data;
                        if (eof) begin
                            len = m_cnt[p] * 4 + ((i_extra_byte == 2'd0) ? 4 : int'(i_extra_byte));
                            m_st[p] = ST_IDLE;
                            if (full || is_runt(len)) begin
                                drops++;
                                frees.push_back(m_slot[p]);
                            end else begin
                                mq.push_back('{m_slot[p], len, p, cyc + 1});
                            end
                        end else begin
                            m_cnt[p]++;
                        end
                    end
                end else if (m_st[p] == ST_DROP && eof) begin
                    m_st[p] = ST_IDLE;
                end
            end
            foreach (frees[k]) m_free[frees[k]] = 1'b1;
            if (take >= 0) m_free[take] = 1'b0;
            e_dcnt = (e_dcnt + drops > 65535) ? 65535 : e_dcnt + drops;
        end
        e_drop = (drops > 0);
        @(posedge i_clk);
        #1;
        chk("mem_we", o_mem_we, e_we);
        if (e_we) begin
            chk("mem_addr", o_mem_addr, e_addr);
            chk("mem_wdata", o_mem_wdata, e_wdata);
        end
        chk("drop", o_drop, e_drop);
        chk("drop_cnt", o_drop_cnt, e_dcnt);
        ev = (mq.size() > 0) && (mq[0].vis <= cyc);
        chk("desc_valid", o_desc_valid, ev);
        if (ev) begin
            chk("desc_slot", o_desc_slot, mq[0].slot);
            chk("desc_len", o_desc_len, mq[0].len);
            chk("desc_port", o_desc_port, mq[0].port);
        end
        if (e_rst) begin
            chk("rst_addr", o_mem_addr, 0);
            chk("rst_wdata", o_mem_wdata, 0);
            chk("rst_desc_slot", o_desc_slot, 0);
            chk("rst_desc_len", o_desc_len, 0);
            chk("rst_desc_port", o_desc_port, 0);
        end
        cyc++;
    endtask

    task automatic word(input int p, input int info, input int ex);
        i_en_mem     = 1'b1;
        i_port_num   = 2'(p);
        i_info_port  = 2'(info);
        i_extra_byte = 2'(ex);
        i_data       = $urandom;
        tick();
        i_en_mem     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic release_slot(input int s);
        i_free_valid = 1'b1;
        i_free_slot  = 4'(s);
        tick();
        i_free_valid = 1'b0;
    endtask

    task automatic release_all();
        while (held.size() > 0) release_slot(held.pop_front());
    endtask

    initial begin
        int r;
        // Reset state.
        i_reset = 1'b1;
        idle(2);
        i_reset = 1'b0;
        idle(1);

        // Single frame on port 00: SOF, 14 middles, EOF with 2 bytes.
        word(0, 1, 0);
        for (int w = 0; w < 14; w++) word(0, 0, 0);
        word(0, 2, 2);
        idle(4);
        release_all();

        // Three ports interleaved round-robin, 20-word frames.
        for (int w = 0; w < 20; w++) begin
            word(0, (w == 0) ? 1 : ((w == 19) ? 2 : 0), 3);
            word(1, (w == 0) ? 1 : ((w == 19) ? 2 : 0), 1);
            word(3, (w == 0) ? 1 : ((w == 19) ? 2 : 0), 0);
        end
        idle(6);
        release_all();

        // Exhaust all slots, overflow SOF, then release slot 5 and reuse it.
        for (int f = 0; f < 16; f++) word(0, 3, 0);
        word(0, 1, 0);
        idle(4);
        for (int k = 0; k < held.size(); k++) begin
            if (held[k] == 5) begin
                held.delete(k);
                break;
            end
        end
        release_slot(5);
        word(1, 3, 1);
        idle(4);
        release_all();

        // 513-word frame overruns the slot; the next frame reuses it.
        word(3, 1, 0);
        for (int w = 0; w < 511; w++) word(3, 0, 0);
        word(3, 2, 0);
        word(3, 3, 2);
        idle(4);
        release_all();

        // Descriptor FIFO back-pressure: 4 queue, 5th dropped, then drain.
        i_desc_ready = 1'b0;
        for (int f = 0; f < 5; f++) word(1, 3, f % 4);
        idle(3);
        i_desc_ready = 1'b1;
        idle(8);
        release_all();

        // Unused port code is ignored entirely.
        word(2, 1, 0);
        word(2, 3, 0);

        // Randomized traffic with random back-pressure and releases.
        for (int n = 0; n < 600; n++) begin
            i_desc_ready = ($urandom_range(0, 3) != 0);
            if (held.size() > 0 && $urandom_range(0, 2) == 0) begin
                i_free_valid = 1'b1;
                i_free_slot  = 4'(held.pop_front());
            end
            if ($urandom_range(0, 3) != 0) begin
                r            = $urandom_range(0, 9);
                i_en_mem     = 1'b1;
                i_port_num   = 2'($urandom_range(0, 3));
                i_info_port  = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
                i_extra_byte = 2'($urandom_range(0, 3));
                i_data       = $urandom;
            end
            tick();
            i_en_mem     = 1'b0;
            i_free_valid = 1'b0;
        end
        i_desc_ready = 1'b1;
        idle(8);
        release_all();

        // Reset in the middle of a port 01 frame, then restart from slot 0.
        word(1, 1, 0);
        for (int w = 0; w < 3; w++) word(1, 0, 0);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        word(0, 3, 0);
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
